// File: rtl/ysyx_23060332_ifu_ctrl.sv
// ysyx_23060332_ifu_ctrl: non-pipelined fetch sequencer owning the PC, one outstanding memory read,
// valid/ready hand-off to IDU and EXU jump redirects that drop any wrong-path fetch in flight.
module ysyx_23060332_ifu_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [AW-1:0] RESET_PC = 32'h80000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] inst_addr,
    output logic [AW-1:0] pc
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t        state;
    logic          drop;
    logic [AW-1:0] tgt;
    logic [AW-1:0] pc_next;

    assign tgt     = {jump_addr[AW-1:2], 2'b00};
    assign pc_next = pc + AW'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            mem_req_addr  <= RESET_PC;
            inst_addr     <= RESET_PC;
            inst_o        <= '0;
            mem_req_valid <= 1'b0;
            inst_valid    <= 1'b0;
            drop          <= 1'b0;
        end else begin
            if (jump_en) pc <= tgt;
            case (state)
                IDLE: begin
                    state         <= REQ;
                    mem_req_valid <= 1'b1;
                    mem_req_addr  <= jump_en ? tgt : pc;
                end
                REQ: begin
                    // the request is never retracted; a redirect only marks its response as stale
                    if (jump_en) drop <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (drop || jump_en) begin
                            drop          <= 1'b0;
                            mem_req_addr  <= jump_en ? tgt : pc;
                            mem_req_valid <= 1'b1;
                            state         <= REQ;
                        end else begin
                            inst_o     <= mem_rsp_data;
                            inst_addr  <= mem_req_addr;
                            inst_valid <= 1'b1;
                            state      <= OUT;
                        end
                    end else if (jump_en) begin
                        drop <= 1'b1;
                    end
                end
                OUT: begin
                    // a redirect wins over an IDU accept in the same cycle
                    if (jump_en || inst_ready) begin
                        inst_valid    <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= jump_en ? tgt : pc_next;
                        state         <= REQ;
                        if (!jump_en) pc <= pc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
